branch_pc_unit: RTL and testbench

//  Downstream consumer of the ALU's carry/zero/sign flags. Latches the flags into an

---
 rtl/branch_pc_unit_if.sv | 22 ++
 rtl/branch_pc_unit.sv | 121 ++++++++++++
 tb/tb_branch_pc_unit.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/branch_pc_unit_if.sv
// Instruction-issue bus into the branch/PC unit: opcode, operands, valid/ready
// handshake and the pipeline stall.
interface branch_pc_unit_if #(
   parameter int PC_WIDTH = 32
);
   logic                valid_in;
   logic [3:0]          br_op;
   logic [PC_WIDTH-1:0] offset;
   logic [PC_WIDTH-1:0] reg_val;
   logic                stall;
   logic                ready;

   modport master (
      output valid_in, br_op, offset, reg_val, stall,
      input  ready
   );

   modport slave (
      input  valid_in, br_op, offset, reg_val, stall,
      output ready
   );
endinterface

// File: rtl/branch_pc_unit.sv
// KGP-RISC branch resolution and PC ownership: latches ALU flags, evaluates
// branch conditions on the registered flags, and sequences the 2-cycle branch-and-link.
module branch_pc_unit #(
   parameter int                  PC_WIDTH = 32,
   parameter logic [PC_WIDTH-1:0] RESET_PC = '0
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                flag_we,
   input  logic                carry_in,
   input  logic                zero_in,
   input  logic                sign_in,
   branch_pc_unit_if.slave     bus,
   output logic [PC_WIDTH-1:0] pc_out,
   output logic                taken,
   output logic                link_we,
   output logic [PC_WIDTH-1:0] link_data,
   output logic                misalign
);

   typedef enum logic [1:0] {
      BOOT = 2'd0,
      RUN  = 2'd1,
      LINK = 2'd2
   } state_t;

   localparam logic [3:0] OP_B    = 4'b0001;
   localparam logic [3:0] OP_BR   = 4'b0010;
   localparam logic [3:0] OP_BLTZ = 4'b0011;
   localparam logic [3:0] OP_BZ   = 4'b0100;
   localparam logic [3:0] OP_BNZ  = 4'b0101;
   localparam logic [3:0] OP_BL   = 4'b0110;
   localparam logic [3:0] OP_BCY  = 4'b0111;
   localparam logic [3:0] OP_BNCY = 4'b1000;

   state_t              state;
   logic                c_flag, z_flag, s_flag;
   logic [PC_WIDTH-1:0] raw_target;
   logic [PC_WIDTH-1:0] target;
   logic [PC_WIDTH-1:0] pc_plus4;
   logic                branch_cond;

   // Conditions use the registered flags, so a flag write in the same cycle
   // as a branch is only visible to the following instruction.
   always_comb begin
      raw_target  = (bus.br_op == OP_BR) ? bus.reg_val : pc_out + bus.offset;
      target      = {raw_target[PC_WIDTH-1:2], 2'b00};
      pc_plus4    = pc_out + PC_WIDTH'(4);
      branch_cond = 1'b0;
      case (bus.br_op)
         OP_B, OP_BR, OP_BL: branch_cond = 1'b1;
         OP_BLTZ:            branch_cond = s_flag;
         OP_BZ:              branch_cond = z_flag;
         OP_BNZ:             branch_cond = ~z_flag;
         OP_BCY:             branch_cond = c_flag;
         OP_BNCY:            branch_cond = ~c_flag;
         default:            branch_cond = 1'b0;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= BOOT;
         pc_out    <= RESET_PC;
         c_flag    <= 1'b0;
         z_flag    <= 1'b0;
         s_flag    <= 1'b0;
         bus.ready <= 1'b0;
         taken     <= 1'b0;
         link_we   <= 1'b0;
         link_data <= '0;
         misalign  <= 1'b0;
      end else begin
         if (flag_we) begin
            c_flag <= carry_in;
            z_flag <= zero_in;
            s_flag <= sign_in;
         end
         // Stall freezes the sequencer entirely; link_we stays up in LINK until it drops.
         if (!bus.stall) begin
            case (state)
               BOOT: begin
                  state     <= RUN;
                  bus.ready <= 1'b1;
               end
               RUN: begin
                  if (bus.valid_in) begin
                     if (branch_cond) begin
                        pc_out <= target;
                        taken  <= 1'b1;
                        if (raw_target[1:0] != 2'b00) misalign <= 1'b1;
                     end else begin
                        pc_out <= pc_plus4;
                        taken  <= 1'b0;
                     end
                     if (bus.br_op == OP_BL) begin
                        link_data <= pc_plus4;
                        link_we   <= 1'b1;
                        bus.ready <= 1'b0;
                        state     <= LINK;
                     end
                  end else begin
                     taken <= 1'b0;
                  end
               end
               LINK: begin
                  link_we   <= 1'b0;
                  bus.ready <= 1'b1;
                  state     <= RUN;
               end
               default: begin
                  state     <= BOOT;
                  bus.ready <= 1'b0;
                  link_we   <= 1'b0;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_branch_pc_unit.sv
// Directed bench for branch_pc_unit: walks reset, sequential fetch, flag hazard,
// branch-and-link with stall, misalignment, PC wrap and reset during LINK.
module tb_branch_pc_unit;

   logic        clk;
   logic        rst;
   logic        flag_we, carry_in, zero_in, sign_in;
   logic [31:0] pc_out, link_data;
   logic        taken, link_we, misalign;
   int          compared;
   int          mismatched;

   branch_pc_unit_if #(.PC_WIDTH(32)) bus ();

   branch_pc_unit #(.PC_WIDTH(32), .RESET_PC(32'h0)) dut (
      .clk       (clk),
      .rst       (rst),
      .flag_we   (flag_we),
      .carry_in  (carry_in),
      .zero_in   (zero_in),
      .sign_in   (sign_in),
      .bus       (bus),
      .pc_out    (pc_out),
      .taken     (taken),
      .link_we   (link_we),
      .link_data (link_data),
      .misalign  (misalign)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Drive one instruction slot, then advance to just after the next rising edge.
   task automatic applyStimulus(input logic v, input logic [3:0] op,
                                input logic [31:0] off, input logic [31:0] rv);
      bus.valid_in = v;
      bus.br_op    = op;
      bus.offset   = off;
      bus.reg_val  = rv;
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   initial begin
      compared     = 0;
      mismatched   = 0;
      rst          = 1'b0;
      flag_we      = 1'b0;
      carry_in     = 1'b0;
      zero_in      = 1'b0;
      sign_in      = 1'b0;
      bus.stall    = 1'b0;
      bus.valid_in = 1'b0;
      bus.br_op    = 4'h0;
      bus.offset   = '0;
      bus.reg_val  = '0;

      #12;
      checkOutput("rst_pc", pc_out, 32'h0);
      checkOutput("rst_ready", {31'd0, bus.ready}, 32'd0);
      checkOutput("rst_taken", {31'd0, taken}, 32'd0);
      checkOutput("rst_link_we", {31'd0, link_we}, 32'd0);
      checkOutput("rst_link_data", link_data, 32'h0);
      checkOutput("rst_misalign", {31'd0, misalign}, 32'd0);

      rst = 1'b1;
      #1;
      checkOutput("boot_ready", {31'd0, bus.ready}, 32'd0);
      applyStimulus(1'b0, 4'h0, 32'h0, 32'h0);
      checkOutput("run_ready", {31'd0, bus.ready}, 32'd1);
      checkOutput("run_pc", pc_out, 32'h0);

      applyStimulus(1'b1, 4'h0, 32'h0, 32'h0);
      checkOutput("seq1_pc", pc_out, 32'h4);
      checkOutput("seq1_taken", {31'd0, taken}, 32'd0);
      applyStimulus(1'b1, 4'h0, 32'h0, 32'h0);
      checkOutput("seq2_pc", pc_out, 32'h8);
      applyStimulus(1'b1, 4'h0, 32'h0, 32'h0);
      checkOutput("seq3_pc", pc_out, 32'hC);
      checkOutput("seq3_taken", {31'd0, taken}, 32'd0);
      applyStimulus(1'b0, 4'h0, 32'h0, 32'h0);
      checkOutput("idle_pc", pc_out, 32'hC);
      applyStimulus(1'b1, 4'h0, 32'h0, 32'h0);
      checkOutput("seq4_pc", pc_out, 32'h10);

      bus.stall = 1'b1;
      applyStimulus(1'b1, 4'h0, 32'h0, 32'h0);
      checkOutput("stall_run_pc", pc_out, 32'h10);
      bus.stall = 1'b0;

      // Flag write coincides with bz: old Z=0 decides this one.
      flag_we = 1'b1;
      zero_in = 1'b1;
      applyStimulus(1'b1, 4'b0100, 32'h20, 32'h0);
      checkOutput("bz_hazard_pc", pc_out, 32'h14);
      checkOutput("bz_hazard_taken", {31'd0, taken}, 32'd0);
      flag_we = 1'b0;
      applyStimulus(1'b1, 4'b0100, 32'h20, 32'h0);
      checkOutput("bz_pc", pc_out, 32'h34);
      checkOutput("bz_taken", {31'd0, taken}, 32'd1);

      applyStimulus(1'b1, 4'b0010, 32'h0, 32'h100);
      checkOutput("br_pc", pc_out, 32'h100);
      checkOutput("br_misalign", {31'd0, misalign}, 32'd0);

      applyStimulus(1'b1, 4'b0110, 32'hFFFF_FFC0, 32'h0);
      checkOutput("bl1_pc", pc_out, 32'hC0);
      checkOutput("bl1_link_data", link_data, 32'h104);
      checkOutput("bl1_link_we", {31'd0, link_we}, 32'd1);
      checkOutput("bl1_ready", {31'd0, bus.ready}, 32'd0);
      checkOutput("bl1_taken", {31'd0, taken}, 32'd1);
      applyStimulus(1'b0, 4'h0, 32'h0, 32'h0);
      checkOutput("bl1_done_link_we", {31'd0, link_we}, 32'd0);
      checkOutput("bl1_done_ready", {31'd0, bus.ready}, 32'd1);
      checkOutput("bl1_done_pc", pc_out, 32'hC0);

      applyStimulus(1'b1, 4'b0110, 32'h40, 32'h0);
      checkOutput("bl2_pc", pc_out, 32'h100);
      checkOutput("bl2_link_data", link_data, 32'hC4);
      bus.stall = 1'b1;
      flag_we   = 1'b1;
      carry_in  = 1'b1;
      zero_in   = 1'b1;
      sign_in   = 1'b0;
      applyStimulus(1'b0, 4'h0, 32'h0, 32'h0);
      checkOutput("bl2_stall1_link_we", {31'd0, link_we}, 32'd1);
      checkOutput("bl2_stall1_ready", {31'd0, bus.ready}, 32'd0);
      flag_we = 1'b0;
      applyStimulus(1'b0, 4'h0, 32'h0, 32'h0);
      checkOutput("bl2_stall2_link_we", {31'd0, link_we}, 32'd1);
      checkOutput("bl2_stall2_pc", pc_out, 32'h100);
      bus.stall = 1'b0;
      applyStimulus(1'b0, 4'h0, 32'h0, 32'h0);
      checkOutput("bl2_done_link_we", {31'd0, link_we}, 32'd0);
      checkOutput("bl2_done_ready", {31'd0, bus.ready}, 32'd1);
      checkOutput("bl2_hold_link_data", link_data, 32'hC4);

      // Flags now C=1 Z=1 S=0 (latched during the stall).
      applyStimulus(1'b1, 4'b0101, 32'h40, 32'h0);
      checkOutput("bnz_pc", pc_out, 32'h104);
      checkOutput("bnz_taken", {31'd0, taken}, 32'd0);
      applyStimulus(1'b1, 4'b0111, 32'h10, 32'h0);
      checkOutput("bcy_pc", pc_out, 32'h114);
      checkOutput("bcy_taken", {31'd0, taken}, 32'd1);
      applyStimulus(1'b1, 4'b0011, 32'h10, 32'h0);
      checkOutput("bltz_pc", pc_out, 32'h118);
      applyStimulus(1'b1, 4'b1000, 32'h10, 32'h0);
      checkOutput("bncy_pc", pc_out, 32'h11C);
      applyStimulus(1'b1, 4'b1111, 32'h10, 32'h0);
      checkOutput("op_f_pc", pc_out, 32'h120);
      checkOutput("op_f_taken", {31'd0, taken}, 32'd0);
      applyStimulus(1'b1, 4'b0001, 32'hFFFF_FFE0, 32'h0);
      checkOutput("b_back_pc", pc_out, 32'h100);
      checkOutput("b_back_taken", {31'd0, taken}, 32'd1);

      applyStimulus(1'b1, 4'b0010, 32'h0, 32'h203);
      checkOutput("br_mis_pc", pc_out, 32'h200);
      checkOutput("br_mis_flag", {31'd0, misalign}, 32'd1);
      applyStimulus(1'b1, 4'b0001, 32'h8, 32'h0);
      checkOutput("sticky_pc", pc_out, 32'h208);
      checkOutput("sticky_misalign", {31'd0, misalign}, 32'd1);

      applyStimulus(1'b1, 4'b0010, 32'h0, 32'hFFFF_FFFC);
      checkOutput("top_pc", pc_out, 32'hFFFF_FFFC);
      applyStimulus(1'b1, 4'h0, 32'h0, 32'h0);
      checkOutput("wrap_pc", pc_out, 32'h0);
      checkOutput("wrap_taken", {31'd0, taken}, 32'd0);

      applyStimulus(1'b1, 4'b0110, 32'h40, 32'h0);
      checkOutput("bl3_pc", pc_out, 32'h40);
      checkOutput("bl3_link_we", {31'd0, link_we}, 32'd1);
      bus.valid_in = 1'b0;
      #2;
      rst = 1'b0;
      #1;
      checkOutput("abort_pc", pc_out, 32'h0);
      checkOutput("abort_link_we", {31'd0, link_we}, 32'd0);
      checkOutput("abort_ready", {31'd0, bus.ready}, 32'd0);
      checkOutput("abort_link_data", link_data, 32'h0);
      checkOutput("abort_misalign", {31'd0, misalign}, 32'd0);
      @(posedge clk);
      #1;
      checkOutput("abort_hold_link_we", {31'd0, link_we}, 32'd0);
      rst = 1'b1;
      applyStimulus(1'b0, 4'h0, 32'h0, 32'h0);
      checkOutput("reboot_ready", {31'd0, bus.ready}, 32'd1);
      checkOutput("reboot_pc", pc_out, 32'h0);
      checkOutput("reboot_link_we", {31'd0, link_we}, 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
